// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// FSM state encoding and requester port indices.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic PORT_IF   = 1'b0;
   localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational two-way picker: single requester wins outright,
// ties go to the port not served last (or always port 1 in fixed mode).
module arb_rr2
   import mem_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_idx   = PORT_IF;
      unique case (1'b1)
         (req0 && req1):  grant_idx = FIXED_PRIO ? PORT_DATA : ~last_grant;
         (req1 && !req0): grant_idx = PORT_DATA;
         default:         grant_idx = PORT_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port fixed-latency memory.
// One access at a time: grant, issue, wait LAT-1 cycles, ack.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int LAT        = 2,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          we0,
   input  logic          we1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          sel,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CW = $clog2(LAT + 1);

   if (LAT < 1) begin : g_lat_chk
      $error("mem_port_arbiter: LAT must be >= 1");
   end

   state_t        st;
   logic [CW-1:0] cnt;
   logic          last_grant;
   logic          we_q;
   logic          gv;
   logic          gi;

   arb_rr2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .grant_valid(gv),
      .grant_idx  (gi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         we_q       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata      <= '0;
         sel        <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         unique case (st)
            IDLE: begin
               if (gv) begin
                  sel        <= gi;
                  last_grant <= gi;
                  mem_addr   <= gi ? addr1 : addr0;
                  mem_wdata  <= gi ? wdata1 : wdata0;
                  mem_we     <= gi ? we1 : we0;
                  we_q       <= gi ? we1 : we0;
                  mem_en     <= 1'b1;
                  busy       <= 1'b1;
                  st         <= ISSUE;
               end
            end
            ISSUE: begin
               cnt <= CW'(LAT - 1);
               // Single-cycle memory: data is already valid this cycle
               if (LAT == 1) begin
                  if (!we_q) rdata <= mem_rdata;
                  ack0 <= ~sel;
                  ack1 <= sel;
                  st   <= RESP;
               end else begin
                  st <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (!we_q) rdata <= mem_rdata;
                  ack0 <= ~sel;
                  ack1 <= sel;
                  st   <= RESP;
               end
            end
            RESP: begin
               busy <= 1'b0;
               st   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: three arbiter builds (RR/LAT2, fixed/LAT2, RR/LAT1)
// checked against a transaction-timeline reference model.
module tb_mem_port_arbiter;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0[N], req1[N], we0[N], we1[N];
   logic [31:0] addr0[N], addr1[N], wdata0[N], wdata1[N];
   logic        ack0[N], ack1[N], sel[N], mem_en[N], mem_we[N], busy[N];
   logic [31:0] rdata[N], mem_addr[N], mem_wdata[N], mem_rdata[N];

   always #5 clk = ~clk;

   function automatic int lat_of(int i);
      return (i == 2) ? 1 : 2;
   endfunction

   function automatic bit fp_of(int i);
      return (i == 1);
   endfunction

   function automatic logic [31:0] init_word(int i, int j);
      if (j == 0) return 32'hDEADBEEF;
      return {16'hC0DE, 4'(i), 8'(j * 17), 4'(j)};
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_port_arbiter #(
         .AW(32), .DW(32),
         .LAT((g == 2) ? 1 : 2),
         .FIXED_PRIO(g == 1)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .req0(req0[g]), .req1(req1[g]),
         .addr0(addr0[g]), .addr1(addr1[g]),
         .wdata0(wdata0[g]), .wdata1(wdata1[g]),
         .we0(we0[g]), .we1(we1[g]),
         .ack0(ack0[g]), .ack1(ack1[g]),
         .rdata(rdata[g]), .sel(sel[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]),
         .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g]), .busy(busy[g])
      );
   end

   // memory behind each DUT: data valid only in the cycle LAT-1 after mem_en
   logic [31:0] tbmem[N][16];
   logic [31:0] junk[N];
   int          age[N];
   bit          seeded;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         junk[i] <= $urandom;
         age[i]  <= mem_en[i] ? 1 : (age[i] != 0 ? age[i] + 1 : 0);
         if (!seeded) begin
            for (int j = 0; j < 16; j++) tbmem[i][j] <= init_word(i, j);
         end else if (mem_en[i] && mem_we[i]) begin
            tbmem[i][mem_addr[i][5:2]] <= mem_wdata[i];
         end
      end
      seeded <= 1'b1;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         mem_rdata[i] = junk[i];
         if ((lat_of(i) == 1) ? mem_en[i] : (age[i] == lat_of(i) - 1))
            mem_rdata[i] = tbmem[i][mem_addr[i][5:2]];
      end
   end

   // reference model state
   int          nchk, nfail, cyc, cur, mode;
   bit          act[N];
   bit          jd[N][2];
   int          iss_c[N], ack_c[N], free_c[N];
   logic        xport[N], xwe[N], last[N], sel_m[N];
   logic [31:0] xrd[N], ma[N], mw[N], rd_m[N];
   logic [31:0] refmem[N][16];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s[%0d] got=%h exp=%h", tag, cur, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         act[i] = 0; last[i] = 1'b1; sel_m[i] = 1'b0;
         ma[i] = '0; mw[i] = '0; rd_m[i] = '0;
         free_c[i] = cyc; jd[i][0] = 0; jd[i][1] = 0;
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < N; i++) begin
         bit iss, rsp;
         cur = i;
         iss = act[i] && cyc == iss_c[i];
         rsp = act[i] && cyc == ack_c[i];
         check("mem_en", 32'(mem_en[i]), 32'(iss));
         check("mem_we", 32'(mem_we[i]), 32'(iss && xwe[i]));
         check("ack0", 32'(ack0[i]), 32'(rsp && !xport[i]));
         check("ack1", 32'(ack1[i]), 32'(rsp && xport[i]));
         check("busy", 32'(busy[i]), 32'(act[i]));
         check("sel", 32'(sel[i]), 32'(sel_m[i]));
         check("mem_addr", mem_addr[i], ma[i]);
         check("mem_wdata", mem_wdata[i], mw[i]);
         if (rsp) begin
            if (!xwe[i]) rd_m[i] = xrd[i];
            check("rdata", rdata[i], rd_m[i]);
            act[i] = 0;
            free_c[i] = cyc + 1;
            jd[i][xport[i]] = 1;
         end
      end
   endtask

   task automatic set_req(int i, int p, logic r);
      if (p == 0) req0[i] = r;
      else        req1[i] = r;
   endtask

   task automatic set_pay(int i, int p, logic [31:0] a, logic [31:0] d, logic w);
      if (p == 0) begin addr0[i] = a; wdata0[i] = d; we0[i] = w; end
      else        begin addr1[i] = a; wdata1[i] = d; we1[i] = w; end
   endtask

   task automatic new_req(int i, int p);
      set_req(i, p, 1'b1);
      set_pay(i, p, $urandom, $urandom, 1'($urandom_range(1)));
   endtask

   // requesters: hold req until ack, may drop or scramble after the grant
   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         for (int p = 0; p < 2; p++) begin
            logic rq;
            bit   g;
            rq = (p == 0) ? req0[i] : req1[i];
            g  = act[i] && (int'(xport[i]) == p);
            if (jd[i][p]) begin
               jd[i][p] = 0;
               if (mode == 2 || (mode == 1 && $urandom_range(1) == 1))
                  new_req(i, p);
               else
                  set_req(i, p, 1'b0);
            end else if (g) begin
               int r;
               r = $urandom_range(7);
               if (r == 0 && mode == 1) set_req(i, p, 1'b0);
               else if (r <= 2)
                  set_pay(i, p, $urandom, $urandom, 1'($urandom_range(1)));
            end else if (!rq && mode != 0) begin
               if (mode == 2 || $urandom_range(1) == 1) new_req(i, p);
            end
         end
      end
   endtask

   // grant decision for the coming edge, expressed as a timeline
   task automatic arbitrate();
      for (int i = 0; i < N; i++) begin
         if (!act[i] && cyc >= free_c[i] && (req0[i] || req1[i])) begin
            logic        w, we;
            logic [31:0] a, d;
            if (req0[i] && req1[i]) w = fp_of(i) ? 1'b1 : !last[i];
            else                    w = req1[i];
            a  = w ? addr1[i] : addr0[i];
            d  = w ? wdata1[i] : wdata0[i];
            we = w ? we1[i] : we0[i];
            act[i] = 1; iss_c[i] = cyc + 1; ack_c[i] = cyc + 1 + lat_of(i);
            xport[i] = w; xwe[i] = we; ma[i] = a; mw[i] = d;
            sel_m[i] = w; last[i] = w;
            if (we) refmem[i][a[5:2]] = d;
            else    xrd[i] = refmem[i][a[5:2]];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
      drive_reqs();
      arbitrate();
   endtask

   task automatic all_req(int p, logic [31:0] a, logic [31:0] d, logic w);
      for (int i = 0; i < N; i++) begin
         set_req(i, p, 1'b1);
         set_pay(i, p, a, d, w);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      nchk = 0; nfail = 0; cyc = 0; mode = 0;
      for (int i = 0; i < N; i++) begin
         req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0;
         addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
         for (int j = 0; j < 16; j++) refmem[i][j] = init_word(i, j);
      end
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check_outputs();
      for (int i = 0; i < N; i++) begin
         cur = i;
         check("rst_rdata", rdata[i], 32'h0);
      end
      repeat (2) step();
      rst_n = 1'b1;
      model_reset();

      all_req(0, 32'h100, 32'h0, 1'b0);
      arbitrate();
      repeat (6) step();
      all_req(1, 32'h200, 32'h12345678, 1'b1);
      arbitrate();
      repeat (6) step();
      all_req(1, 32'h200, 32'h0, 1'b0);
      arbitrate();
      repeat (6) step();

      mode = 2;
      repeat (40) step();
      mode = 1;
      repeat (300) step();
      mode = 0;
      repeat (10) step();

      // reset dropped in while LAT=2 instances sit in WAIT
      all_req(0, $urandom, 32'h0, 1'b0);
      all_req(1, $urandom, 32'h0, 1'b0);
      arbitrate();
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      for (int i = 0; i < N; i++) begin
         cur = i;
         check("rst_rdata", rdata[i], 32'h0);
         req0[i] = 0; req1[i] = 0;
      end
      step();
      rst_n = 1'b1;
      model_reset();
      all_req(0, 32'h104, 32'h0, 1'b0);
      all_req(1, 32'h108, 32'h0, 1'b0);
      arbitrate();
      repeat (12) step();

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters: port 0 (instruction fetch) and port 1 (load/store data).
- Arbitrates between them, latches the winner's address, write data and write enable, then sequences one fixed-latency memory access.
- Returns read data to the winner with a one-cycle ack.
- Exports `sel`, the winner index, for the downstream 32-bit 2:1 select on the memory address/data path.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid. Legal range is LAT >= 1; LAT = 0 is illegal and is asserted at elaboration.
- FIXED_PRIO, 0, tie-break mode. 0 = round-robin; 1 = port 1 always wins ties.

Ports:
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held high until the matching ack
- addr0 / addr1  in  AW  request address
- wdata0 / wdata1  in  DW  write data
- we0 / we1  in  1  1 = write, 0 = read
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DW  read data, valid while ack0 or ack1 is high
- sel  out  1  granted port index
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE.
  - ack0, ack1, mem_en, mem_we, busy = 0.
  - sel, mem_addr, mem_wdata, rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requesting, FIXED_PRIO = 0: grant !last_grant.
  - Both requesting, FIXED_PRIO = 1: grant port 1.
  - On a grant at this edge: sel <= winner, last_grant <= winner, latch the winner's addr/wdata/we into mem_addr/mem_wdata/mem_we, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we = latched we. mem_we is 0 in every other state.
  - Load counter with LAT-1.
  - If LAT = 1, the next state is RESP and mem_rdata is captured into rdata at this edge. Otherwise the next state is WAIT.
- WAIT:
  - Decrement the counter each cycle. The counter is $clog2(LAT+1) bits and never wraps.
  - When the counter reaches 1, capture mem_rdata into rdata and go to RESP.
  - WAIT lasts exactly LAT-1 cycles.
- Write transactions: rdata is not updated; it keeps its previous value.
- RESP (exactly 1 cycle):
  - ack[sel] = 1; the other ack stays 0.
  - Next state is IDLE unconditionally.
- Latency:
  - Request sampled at edge E0 → ISSUE in cycle E0+1 → ack in cycle E0+LAT+1.
  - Back-to-back throughput is one transaction per LAT+2 cycles.
- sel, mem_addr and mem_wdata stay stable from ISSUE through RESP, and keep their last value in IDLE.
- A requester dropping req mid-transaction does not abort the access; its ack is still issued.
- addr/wdata/we changes after the grant edge are ignored.
- A requester may hold req high across its own ack to issue the next access. Arbitration happens again in IDLE, so under contention the other port is served next (round-robin mode).
- Reset asserted mid-transaction: the transaction is dropped with no ack, and all outputs take their reset values asynchronously.
- Never both acks high; never ack without a preceding ISSUE.

Decomposition:
- Shared package (`mem_arb_pkg`):
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - Port index constants PORT_IF = 0, PORT_DATA = 1.
- One sub-module, `arb_rr2`: combinational 2-way picker.
  - Inputs: req0, req1, last_grant, FIXED_PRIO.
  - Outputs: grant_valid, grant_idx.
- FSM, counter and latches live in the top.

Test Plan:
1. Reset then single read: LAT = 2, req0 = 1, addr0 = 0x100, mem_rdata = 0xDEADBEEF when sampled → mem_en high 1 cycle with mem_addr = 0x100; ack0 = 1 in cycle E0+3 with rdata = 0xDEADBEEF; sel = 0; ack1 never high.
2. Simultaneous requests, round-robin: req0 = req1 = 1 held → grant order 0, 1, 0, 1; every ack is LAT+2 = 4 cycles apart; sel toggles each transaction.
3. FIXED_PRIO = 1, both requesting continuously → only port 1 is served; ack1 every 4 cycles; ack0 stays 0.
4. Write from port 1: we1 = 1, addr1 = 0x200, wdata1 = 0x12345678 → mem_en = mem_we = 1 for exactly one cycle with those values; ack1 = 1; rdata unchanged from its previous value.
5. LAT = 1 build: single read → WAIT never entered; ack in cycle E0+2; mem_rdata captured at the ISSUE edge.
6. Reset mid-operation: rst_n pulled low during WAIT → all outputs go to 0 immediately with no ack. After release, a reissued req0 completes normally and port 0 wins a tie (last_grant = 1).
